modulo_controlador_jogo: RTL and testbench

Game sequencer for the naval-battle board. Debounces the confirmation button and walks the game through its idle, positioning, attack, check and end phases. Drives the load, clear and write strobes of the position and attack matrix registers, and keeps the hit and shot counters for the 7-segment status path. Sits between the board switches (hh1, hh2, button_confirmation) and the matrix/display datapath.

---
 rtl/modulo_controlador_jogo.sv | 190 +++++++++++++++++++
 tb/tb_modulo_controlador_jogo.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modulo_controlador_jogo.sv
// Game sequencer for the naval-battle board.
// Debounces the confirmation button, walks the game through its phases,
// strobes the matrix registers and keeps the hit/shot counters.
module modulo_controlador_jogo #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SHIP_CELLS      = 6,
   parameter int MAX_SHOTS       = 15
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       button_confirmation,
   input  logic [1:0] hh1,
   input  logic [5:0] hh2,
   input  logic       hit_in,
   input  logic       shot_in,
   output logic [5:0] coord_q,
   output logic       pos_load,
   output logic       mat_clr,
   output logic       at_write,
   output logic [2:0] state,
   output logic [1:0] result,
   output logic [3:0] hits,
   output logic [3:0] shots,
   output logic       game_over,
   output logic       win
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POS   = 3'd1,
      S_ATK   = 3'd2,
      S_CHECK = 3'd3,
      S_WIN   = 3'd4,
      S_LOSE  = 3'd5
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;
   logic          w_press;

   state_t        r_state;
   logic [5:0]    r_coord;
   logic [1:0]    r_result;
   logic [3:0]    r_hits;
   logic [3:0]    r_shots;
   logic          r_pos_load;
   logic          r_mat_clr;
   logic          r_at_write;
   logic          r_game_over;
   logic          r_win;

   logic [3:0]    w_hits_inc;
   logic [3:0]    w_shots_inc;
   logic [3:0]    w_hits_new;
   logic          w_coord_bad;

   // Synchronize the raw button and accept a new level only after it stays stable
   always_ff @(posedge clk) begin
      if (!clr) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_level <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= button_confirmation;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   // Press fires in the cycle the debounced level is about to fall (release is silent)
   assign w_press = r_level & ~r_sync2 & (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

   // Saturating counter increments and coordinate range check
   always_comb begin
      w_hits_inc  = (r_hits  == 4'd15) ? r_hits  : r_hits  + 4'd1;
      w_shots_inc = (r_shots == 4'd15) ? r_shots : r_shots + 4'd1;
      if (hit_in) begin
         w_hits_new = w_hits_inc;
      end else begin
         w_hits_new = r_hits;
      end
      w_coord_bad = (hh2[5:3] > 3'd6) | (hh2[2:0] > 3'd4);
   end

   // Game FSM with registered strobes, counters and status outputs
   always_ff @(posedge clk) begin
      if (!clr) begin
         r_state     <= S_IDLE;
         r_coord     <= 6'd0;
         r_result    <= 2'b00;
         r_hits      <= 4'd0;
         r_shots     <= 4'd0;
         r_pos_load  <= 1'b0;
         r_mat_clr   <= 1'b0;
         r_at_write  <= 1'b0;
         r_game_over <= 1'b0;
         r_win       <= 1'b0;
      end else begin
         r_pos_load <= 1'b0;
         r_mat_clr  <= 1'b0;
         r_at_write <= 1'b0;
         if ((r_state != S_IDLE) && (hh1 == 2'b00)) begin
            // Abort back to idle wins over any press or pending check
            r_state     <= S_IDLE;
            r_mat_clr   <= 1'b1;
            r_coord     <= 6'd0;
            r_result    <= 2'b00;
            r_hits      <= 4'd0;
            r_shots     <= 4'd0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_press && hh1[0]) begin
                     r_pos_load <= 1'b1;
                     r_state    <= S_POS;
                  end
               end
               S_POS: begin
                  if (w_press && (hh1 == 2'b10)) begin
                     r_state <= S_ATK;
                  end
               end
               S_ATK: begin
                  if (w_press) begin
                     r_coord <= hh2;
                     if (w_coord_bad) begin
                        r_result <= 2'b11;
                     end else begin
                        r_state <= S_CHECK;
                     end
                  end
               end
               S_CHECK: begin
                  if (shot_in) begin
                     r_result <= 2'b11;
                     r_state  <= S_ATK;
                  end else begin
                     r_at_write <= 1'b1;
                     r_shots    <= w_shots_inc;
                     r_hits     <= w_hits_new;
                     r_result   <= hit_in ? 2'b10 : 2'b01;
                     if (w_hits_new == 4'(SHIP_CELLS)) begin
                        r_state     <= S_WIN;
                        r_game_over <= 1'b1;
                        r_win       <= 1'b1;
                     end else if (w_shots_inc == 4'(MAX_SHOTS)) begin
                        r_state     <= S_LOSE;
                        r_game_over <= 1'b1;
                     end else begin
                        r_state <= S_ATK;
                     end
                  end
               end
               S_WIN, S_LOSE: begin
                  r_state <= r_state;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign coord_q   = r_coord;
   assign pos_load  = r_pos_load;
   assign mat_clr   = r_mat_clr;
   assign at_write  = r_at_write;
   assign state     = r_state;
   assign result    = r_result;
   assign hits      = r_hits;
   assign shots     = r_shots;
   assign game_over = r_game_over;
   assign win       = r_win;

endmodule

// File: tb/tb_modulo_controlador_jogo.sv
// Self-checking bench for modulo_controlador_jogo: randomized games against
// a game-rule scoreboard, plus debounce latency, abort and reset cases.
module tb_modulo_controlador_jogo;

   localparam int DB = 8;
   localparam int SC = 2;
   localparam int MS = 3;

   logic       clk = 1'b0;
   logic       clr;
   logic       button_confirmation;
   logic [1:0] hh1;
   logic [5:0] hh2;
   logic       hit_in;
   logic       shot_in;
   logic [5:0] coord_q;
   logic       pos_load, mat_clr, at_write;
   logic [2:0] state;
   logic [1:0] result;
   logic [3:0] hits, shots;
   logic       game_over, win;

   always #5 clk = ~clk;

   modulo_controlador_jogo #(.DEBOUNCE_CYCLES(DB), .SHIP_CELLS(SC), .MAX_SHOTS(MS)) dut (
      .clk(clk), .clr(clr), .button_confirmation(button_confirmation),
      .hh1(hh1), .hh2(hh2), .hit_in(hit_in), .shot_in(shot_in),
      .coord_q(coord_q), .pos_load(pos_load), .mat_clr(mat_clr), .at_write(at_write),
      .state(state), .result(result), .hits(hits), .shots(shots),
      .game_over(game_over), .win(win)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Matrix datapath environment: position/attack bits addressed by the raw coordinate
   logic [63:0] env_pos = '0;
   logic [63:0] env_atk = '0;
   logic [63:0] preset  = '0;
   always @(posedge clk) begin
      if (mat_clr) begin
         env_pos <= '0;
         env_atk <= '0;
      end else begin
         if (pos_load) env_pos <= preset;
         if (at_write) env_atk[coord_q] <= 1'b1;
      end
   end
   assign hit_in  = env_pos[coord_q];
   assign shot_in = env_atk[coord_q];

   // Strobe pulse counters and exclusivity monitor
   int n_pos = 0, n_clr = 0, n_wr = 0, n_excl = 0;
   always @(negedge clk) begin
      if (pos_load) n_pos <= n_pos + 1;
      if (mat_clr)  n_clr <= n_clr + 1;
      if (at_write) n_wr  <= n_wr + 1;
      if (int'(pos_load) + int'(mat_clr) + int'(at_write) > 1) n_excl <= n_excl + 1;
   end

   // Game-rule scoreboard
   int          m_state, m_hits, m_shots, m_result, m_coord;
   int          exp_wr = 0, exp_pos = 0, exp_clr = 0;
   logic [63:0] m_fleet;
   logic [63:0] m_shot;
   logic [5:0]  f0, f1;

   task automatic model_clear();
      m_state = 0; m_hits = 0; m_shots = 0; m_result = 0; m_coord = 0; m_shot = '0;
   endtask

   task automatic model_shot(input logic [5:0] c);
      if (m_state != 2) return;
      m_coord = int'(c);
      if (c[5:3] == 3'd7 || c[2:0] > 3'd4) begin
         m_result = 3;
      end else if (m_shot[c]) begin
         m_result = 3;
      end else begin
         m_shot[c] = 1'b1;
         exp_wr++;
         if (m_shots < 15) m_shots++;
         if (m_fleet[c]) begin
            if (m_hits < 15) m_hits++;
            m_result = 2;
         end else begin
            m_result = 1;
         end
         if (m_hits == SC) m_state = 4;
         else if (m_shots == MS) m_state = 5;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".state"}, int'(state), m_state);
      chk({tag, ".result"}, int'(result), m_result);
      chk({tag, ".hits"}, int'(hits), m_hits);
      chk({tag, ".shots"}, int'(shots), m_shots);
      chk({tag, ".coord"}, int'(coord_q), m_coord);
      chk({tag, ".game_over"}, int'(game_over), int'(m_state == 4 || m_state == 5));
      chk({tag, ".win"}, int'(win), int'(m_state == 4));
      chk({tag, ".writes"}, n_wr, exp_wr);
   endtask

   function automatic logic [5:0] rnd_valid();
      logic [2:0] l, c;
      l = 3'($urandom_range(0, 6));
      c = 3'($urandom_range(0, 4));
      return {l, c};
   endfunction

   function automatic logic [5:0] rnd_invalid();
      logic [2:0] l, c;
      if ($urandom_range(0, 1) == 0) begin
         l = 3'd7;
         c = 3'($urandom_range(0, 7));
      end else begin
         l = 3'($urandom_range(0, 6));
         c = 3'($urandom_range(5, 7));
      end
      return {l, c};
   endfunction

   function automatic logic [5:0] rnd_miss();
      logic [5:0] c;
      c = rnd_valid();
      while (m_fleet[c] || m_shot[c]) c = rnd_valid();
      return c;
   endfunction

   task automatic pick_fleet(input bit directed);
      f0 = directed ? 6'o23 : rnd_valid();
      f1 = rnd_valid();
      while (f1 == f0) f1 = rnd_valid();
      preset     = '0;
      preset[f0] = 1'b1;
      preset[f1] = 1'b1;
      m_fleet    = preset;
   endtask

   task automatic press_btn();
      @(negedge clk) button_confirmation = 1'b0;
      repeat (14) @(negedge clk);
      button_confirmation = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic shoot(input logic [5:0] c, input string tag);
      hh2 = c;
      press_btn();
      model_shot(c);
      check_all(tag);
   endtask

   task automatic new_game(input logic [1:0] mode);
      pick_fleet(1'b0);
      model_clear();
      hh1 = mode;
      press_btn();
      exp_pos++;
      chk("start.pos_load", n_pos, exp_pos);
      chk("start.state_pos", int'(state), 1);
      hh1 = 2'b10;
      press_btn();
      chk("start.state_atk", int'(state), 2);
      m_state = 2;
   endtask

   task automatic abort_game(input string tag);
      @(negedge clk) hh1 = 2'b00;
      repeat (3) @(negedge clk);
      if (m_state != 0) exp_clr++;
      model_clear();
      check_all(tag);
      chk({tag, ".mat_clr"}, n_clr, exp_clr);
   endtask

   initial begin
      int lat;
      clr = 1'b0; button_confirmation = 1'b0; hh1 = 2'b00; hh2 = 6'd0;
      model_clear();
      m_fleet = '0;

      // Reset with the button held low
      repeat (5) @(negedge clk);
      check_all("reset");
      chk("reset.strobes", int'(pos_load) + int'(mat_clr) + int'(at_write), 0);
      clr = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_idle.state", int'(state), 0);
      chk("held_idle.pos_load", n_pos, 0);
      button_confirmation = 1'b1;
      repeat (14) @(negedge clk);

      // Bounce shorter than the debounce window, then a clean press in IDLE
      pick_fleet(1'b1);
      hh1 = 2'b01;
      for (int i = 0; i < 30; i++) begin
         button_confirmation = ~button_confirmation;
         repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      button_confirmation = 1'b1;
      repeat (6) @(negedge clk);
      button_confirmation = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (pos_load) begin
            lat = k;
            break;
         end
      end
      chk("debounce.latency", lat, 2 + DB);
      repeat (20) @(negedge clk);
      exp_pos = 1;
      chk("debounce.one_press", n_pos, exp_pos);
      chk("debounce.state_pos", int'(state), 1);
      button_confirmation = 1'b1;
      repeat (14) @(negedge clk);

      // POS ignores presses other than attack mode
      press_btn();
      chk("pos.ignore", int'(state), 1);
      hh1 = 2'b10;
      press_btn();
      chk("pos.to_atk", int'(state), 2);
      m_state = 2;

      // Directed shots: hit, repeat, invalid line, invalid column, then abort
      shoot(6'o23, "hit_o23");
      shoot(6'o23, "repeat_o23");
      shoot({3'd7, 3'($urandom_range(0, 4))}, "bad_line");
      shoot({3'($urandom_range(0, 6)), 3'd5}, "bad_col");
      abort_game("abort_atk");

      // Hit, miss, hit wins; later presses ignored
      new_game(2'b11);
      shoot(f0, "win.hit1");
      shoot(rnd_miss(), "win.miss");
      shoot(f1, "win.hit2");
      shoot(rnd_miss(), "win.ignored");
      abort_game("abort_win");

      // Three misses lose; later presses ignored
      new_game(2'b01);
      for (int s = 0; s < MS; s++) shoot(rnd_miss(), "lose.miss");
      shoot(f0, "lose.ignored");
      abort_game("abort_lose");

      // Randomized games
      for (int g = 0; g < 6; g++) begin
         new_game($urandom_range(0, 1) == 0 ? 2'b01 : 2'b11);
         for (int s = 0; s < 10; s++) begin
            int r;
            logic [5:0] c;
            r = int'($urandom_range(0, 9));
            if (r < 2) c = rnd_invalid();
            else if (r < 5) c = ($urandom_range(0, 1) == 0) ? f0 : f1;
            else c = rnd_valid();
            shoot(c, "rnd");
            if (m_state != 2) break;
         end
         abort_game("rnd.abort");
      end

      // Reset asserted while in CHECK drops the pending write
      new_game(2'b01);
      hh2 = rnd_miss();
      @(negedge clk) button_confirmation = 1'b0;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (state == 3'd3) begin
            lat = k;
            break;
         end
      end
      chk("clr_check.reached", int'(lat >= 0), 1);
      clr = 1'b0;
      @(negedge clk);
      button_confirmation = 1'b1;
      repeat (2) @(negedge clk);
      model_clear();
      check_all("clr_check");
      chk("clr_check.strobes", int'(pos_load) + int'(mat_clr) + int'(at_write), 0);
      clr = 1'b1;
      repeat (3) @(negedge clk);

      chk("strobe.exclusive", n_excl, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
